// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant over valid/ready request channels, one-entry response
// register with per-requester valid/ready return and backpressure.

// Per-requester slice: request handshake and response ownership for one port.
module alu_share_port #(
   parameter bit ID = 1'b0
) (
   input  logic gnt_vld,
   input  logic gnt_id,
   input  logic can_accept,
   input  logic full,
   input  logic owner,
   input  logic rsp_rdy,
   output logic req_rdy,
   output logic rsp_vld,
   output logic drain
);

   // Ready only when this port holds the grant and the register can take data.
   assign req_rdy = can_accept & gnt_vld & (gnt_id == ID);
   // Response is visible only to the port that owns the register contents.
   assign rsp_vld = full & (owner == ID);
   // The owner's consume; the other port's rsp_ready never reaches here.
   assign drain   = rsp_vld & rsp_rdy;

endmodule

module alu_share_arbiter #(
   parameter int ALU_INSTRUCTION_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter logic [ALU_INSTRUCTION_WIDTH-1:0] IDLE_CTL = 4'hF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [1:0]                       req_valid,
   output logic [1:0]                       req_ready,
   input  logic [ALU_INSTRUCTION_WIDTH-1:0] req_ctl0,
   input  logic [DATA_WIDTH-1:0]            req_a0,
   input  logic [DATA_WIDTH-1:0]            req_b0,
   input  logic [ALU_INSTRUCTION_WIDTH-1:0] req_ctl1,
   input  logic [DATA_WIDTH-1:0]            req_a1,
   input  logic [DATA_WIDTH-1:0]            req_b1,
   output logic [ALU_INSTRUCTION_WIDTH-1:0] alu_ctl,
   output logic [DATA_WIDTH-1:0]            alu_a,
   output logic [DATA_WIDTH-1:0]            alu_b,
   input  logic [DATA_WIDTH-1:0]            alu_res,
   input  logic                             alu_zero,
   output logic [1:0]                       rsp_valid,
   input  logic [1:0]                       rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic                             rsp_zero,
   output logic [15:0]                      busy_cnt
);

   localparam int NUM_REQ = 2;

   typedef struct packed {
      logic [ALU_INSTRUCTION_WIDTH-1:0] ctl;
      logic [DATA_WIDTH-1:0]            a;
      logic [DATA_WIDTH-1:0]            b;
   } alu_req_t;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

   alu_req_t         req [NUM_REQ];
   rsp_state_t       state, state_nxt;
   logic             full;
   logic             owner;
   logic             last;
   logic             gnt_vld;
   logic             gnt_id;
   logic             can_accept;
   logic             accept;
   logic [1:0]       drain_vec;
   logic             drain;

   assign req[0] = '{ctl: req_ctl0, a: req_a0, b: req_b0};
   assign req[1] = '{ctl: req_ctl1, a: req_a1, b: req_b1};

   assign full = (state == RSP_FULL);

   // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      case (req_valid)
         2'b01: begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
         end
         2'b10: begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
         end
         2'b11: begin
            gnt_vld = 1'b1;
            gnt_id  = ~last;
         end
         default: begin
            gnt_vld = 1'b0;
            gnt_id  = 1'b0;
         end
      endcase
   end

   // Per-port handshake slices.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
      alu_share_port #(
         .ID (i == 1)
      ) u_port (
         .gnt_vld    (gnt_vld),
         .gnt_id     (gnt_id),
         .can_accept (can_accept),
         .full       (full),
         .owner      (owner),
         .rsp_rdy    (rsp_ready[i]),
         .req_rdy    (req_ready[i]),
         .rsp_vld    (rsp_valid[i]),
         .drain      (drain_vec[i])
      );
   end

   assign drain = |drain_vec;

   // Empty register, or one being consumed this edge, can take a new result.
   // Held off while reset is asserted so nothing is accepted into a clearing register.
   assign can_accept = ~rst & (~full | drain);

   assign accept = |(req_valid & req_ready);

   // ALU operands follow the grant even while stalled so the result settles;
   // with no grant the idle code selects the ALU's zero-result default arm.
   always_comb begin
      alu_ctl = IDLE_CTL;
      alu_a   = '0;
      alu_b   = '0;
      if (gnt_vld) begin
         alu_ctl = req[gnt_id].ctl;
         alu_a   = req[gnt_id].a;
         alu_b   = req[gnt_id].b;
      end
   end

   // Response-register occupancy state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RSP_EMPTY;
      else     state <= state_nxt;
   end

   // Next occupancy: a refill wins over a drain in the same cycle.
   always_comb begin
      state_nxt = state;
      if (accept)     state_nxt = RSP_FULL;
      else if (drain) state_nxt = RSP_EMPTY;
   end

   // Capture the ALU result, owner and round-robin pointer on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_data <= '0;
         rsp_zero <= 1'b0;
         owner    <= 1'b0;
         last     <= 1'b1;
      end else if (accept) begin
         rsp_data <= alu_res;
         rsp_zero <= alu_zero;
         owner    <= gnt_id;
         last     <= gnt_id;
      end
   end

   // Saturating count of accepted operations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  busy_cnt <= '0;
      else if (accept && (busy_cnt != 16'hFFFF)) busy_cnt <= busy_cnt + 16'd1;
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus with a response scoreboard.
// A behavioural ALU closes the loop; expected responses are queued as ops are
// issued and a negedge monitor pops them on every response handshake.
module tb_alu_share_arbiter;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] IDLE    = 4'hF;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_ctl0, req_ctl1;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [3:0]  alu_ctl;
   logic [31:0] alu_a, alu_b, alu_res;
   logic        alu_zero;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_zero;
   logic [15:0] busy_cnt;

   typedef struct {
      logic        port;
      logic [31:0] data;
      logic        zero;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_share_arbiter #(
      .ALU_INSTRUCTION_WIDTH (4),
      .DATA_WIDTH            (32),
      .IDLE_CTL              (IDLE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ctl0  (req_ctl0),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_ctl1  (req_ctl1),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .alu_ctl   (alu_ctl),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_res   (alu_res),
      .alu_zero  (alu_zero),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_zero  (rsp_zero),
      .busy_cnt  (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; unknown codes fall into a zero-result, Zero=0 default arm.
   always_comb begin
      alu_res  = 32'd0;
      alu_zero = 1'b0;
      case (alu_ctl)
         OP_AND: begin alu_res = alu_a & alu_b; alu_zero = ((alu_a & alu_b) == 32'd0); end
         OP_OR:  begin alu_res = alu_a | alu_b; alu_zero = ((alu_a | alu_b) == 32'd0); end
         OP_ADD: begin alu_res = alu_a + alu_b; alu_zero = ((alu_a + alu_b) == 32'd0); end
         OP_SUB: begin alu_res = alu_a - alu_b; alu_zero = ((alu_a - alu_b) == 32'd0); end
         default: begin alu_res = 32'd0; alu_zero = 1'b0; end
      endcase
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic port, input logic [31:0] data, input logic zero);
      exp_t e;
      e.port = port;
      e.data = data;
      e.zero = zero;
      sbq.push_back(e);
   endtask

   // Next cycle: inputs change 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every response handshake consumes the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && ((rsp_valid & rsp_ready) != 2'b00)) begin
         if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got valid=%b data=0x%0h, expected no response", rsp_valid, rsp_data);
         end else begin
            mon_e = sbq.pop_front();
            check("rsp_port",  {30'd0, rsp_valid}, mon_e.port ? 32'd2 : 32'd1);
            check("rsp_data",  rsp_data, mon_e.data);
            check("rsp_zero",  {31'd0, rsp_zero}, {31'd0, mon_e.zero});
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      req_ctl0 = OP_ADD; req_a0 = 32'd0; req_b0 = 32'd0;
      req_ctl1 = OP_ADD; req_a1 = 32'd0; req_b1 = 32'd0;

      // Reset state
      #12;
      check("rst_req_ready", {30'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      check("rst_rsp_data",  rsp_data, 32'd0);
      check("rst_rsp_zero",  {31'd0, rsp_zero}, 32'd0);
      check("rst_busy_cnt",  {16'd0, busy_cnt}, 32'd0);
      req_valid = 2'b00;
      step();
      rst = 1'b0;

      // Tie after reset: requester 0 first, then requester 1
      step();
      req_valid = 2'b11;
      req_ctl0 = OP_SUB; req_a0 = 32'd9;    req_b0 = 32'd9;
      req_ctl1 = OP_OR;  req_a1 = 32'hF0;   req_b1 = 32'h0F;
      #1;
      check("tie_ready0", {30'd0, req_ready}, 32'd1);
      check("tie_alu_ctl", {28'd0, alu_ctl}, {28'd0, OP_SUB});
      push(1'b0, 32'd0, 1'b1);
      step();
      req_valid = 2'b10;
      #1;
      check("tie_rsp_valid0", {30'd0, rsp_valid}, 32'd1);
      check("tie_ready1", {30'd0, req_ready}, 32'd2);
      push(1'b1, 32'hFF, 1'b0);
      step();
      req_valid = 2'b00;
      #1;
      check("tie_rsp_valid1", {30'd0, rsp_valid}, 32'd2);
      check("tie_busy", {16'd0, busy_cnt}, 32'd2);

      // Single op
      step();
      req_valid = 2'b01;
      req_ctl0 = OP_ADD; req_a0 = 32'd5; req_b0 = 32'd7;
      #1;
      check("single_ready", {30'd0, req_ready}, 32'd1);
      push(1'b0, 32'd12, 1'b0);
      step();
      req_valid = 2'b00;
      #1;
      check("single_rsp_valid", {30'd0, rsp_valid}, 32'd1);
      check("single_busy", {16'd0, busy_cnt}, 32'd3);

      // Backpressure: owner stalls, other requester waits with its operands on the ALU
      step();
      req_valid = 2'b01;
      rsp_ready = 2'b00;
      req_ctl0 = OP_ADD; req_a0 = 32'd1; req_b0 = 32'd1;
      #1;
      check("bp_first_ready", {30'd0, req_ready}, 32'd1);
      push(1'b0, 32'd2, 1'b0);
      step();
      req_valid = 2'b10;
      req_ctl1 = OP_ADD; req_a1 = 32'h10; req_b1 = 32'h20;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_ready_stall", {30'd0, req_ready}, 32'd0);
         check("bp_rsp_valid",   {30'd0, rsp_valid}, 32'd1);
         check("bp_rsp_data",    rsp_data, 32'd2);
         check("bp_alu_a",       alu_a, 32'h10);
         if (k == 1) rsp_ready = 2'b10;  // non-owner ready must be ignored
         step();
      end
      rsp_ready = 2'b01;
      #1;
      check("bp_release_ready", {30'd0, req_ready}, 32'd2);
      push(1'b1, 32'h30, 1'b0);
      step();
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      #1;
      check("bp_switch_valid", {30'd0, rsp_valid}, 32'd2);
      check("bp_switch_data",  rsp_data, 32'h30);

      // Fairness: both continuously valid, grants alternate starting with 0
      step();
      req_valid = 2'b11;
      req_ctl0 = OP_ADD; req_a0 = 32'd3; req_b0 = 32'd4;
      req_ctl1 = OP_SUB; req_a1 = 32'd5; req_b1 = 32'd5;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("fair_grant", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k % 2 == 0) push(1'b0, 32'd7, 1'b0);
         else            push(1'b1, 32'd0, 1'b1);
         step();
      end
      req_valid = 2'b00;
      #1;
      check("fair_busy", {16'd0, busy_cnt}, 32'd13);

      // Idle drive
      check("idle_ctl",   {28'd0, alu_ctl}, {28'd0, IDLE});
      check("idle_a",     alu_a, 32'd0);
      check("idle_b",     alu_b, 32'd0);
      check("idle_ready", {30'd0, req_ready}, 32'd0);

      // Async reset while requester 1 holds a stalled response (discarded)
      step();
      req_valid = 2'b10;
      rsp_ready = 2'b00;
      req_ctl1 = OP_ADD; req_a1 = 32'd2; req_b1 = 32'd2;
      #1;
      check("ar_ready", {30'd0, req_ready}, 32'd2);
      step();
      req_valid = 2'b00;
      #1;
      check("ar_rsp_valid_pre", {30'd0, rsp_valid}, 32'd2);
      rst = 1'b1;
      #1;
      check("ar_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      check("ar_rsp_data",  rsp_data, 32'd0);
      check("ar_busy",      {16'd0, busy_cnt}, 32'd0);
      rsp_ready = 2'b11;
      step();
      rst = 1'b0;
      step();
      req_valid = 2'b11;
      req_ctl0 = OP_AND; req_a0 = 32'hF0; req_b0 = 32'hFF;
      req_ctl1 = OP_OR;  req_a1 = 32'h1;  req_b1 = 32'h2;
      #1;
      check("ar_tie_ready", {30'd0, req_ready}, 32'd1);
      push(1'b0, 32'hF0, 1'b0);
      step();
      req_valid = 2'b00;
      #1;
      check("ar_busy_after", {16'd0, busy_cnt}, 32'd1);
      check("ar_rsp_valid_after", {30'd0, rsp_valid}, 32'd1);

      step();
      step();
      check("sb_empty", sbq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. port 0 = execute stage and port 1 = address/branch helper.
- Round-robin arbitration over valid/ready request channels.
- Drives the ALU operand and control inputs from the granted requester.
- Captures alu_o/Zero into one response register, returned on a per-requester valid/ready response channel with backpressure.

Parameters:
- ALU_INSTRUCTION_WIDTH, 4, width of the ALU control code.
- DATA_WIDTH, 32, operand/result width; fixed at 32 in this design.
- IDLE_CTL, 4'hF, control code driven to the ALU when nothing is granted. It must decode to the ALU default arm, where result and Zero are 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: requester i's operation is accepted this cycle.
- req_ctl0  input  ALU_INSTRUCTION_WIDTH  requester 0 ALU control code.
- req_a0  input  32  requester 0 operand a.
- req_b0  input  32  requester 0 operand b.
- req_ctl1  input  ALU_INSTRUCTION_WIDTH  requester 1 ALU control code.
- req_a1  input  32  requester 1 operand a.
- req_b1  input  32  requester 1 operand b.
- alu_ctl  output  ALU_INSTRUCTION_WIDTH  to ALU ALUCtl.
- alu_a  output  32  to ALU a.
- alu_b  output  32  to ALU b.
- alu_res  input  32  from ALU alu_o.
- alu_zero  input  1  from ALU Zero.
- rsp_valid  output  2  bit i: response register holds requester i's result. At most one bit is set.
- rsp_ready  input  2  bit i: requester i consumes its response.
- rsp_data  output  32  captured ALU result.
- rsp_zero  output  1  captured ALU Zero flag.
- busy_cnt  output  16  saturating count of accepted operations since reset.

Behaviour:
- Reset (async, rst=1):
  - rsp_valid=0, rsp_data=0, rsp_zero=0, busy_cnt=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - req_ready=0 while rst is asserted.
- State:
  - Response register: full/empty flag plus owner id.
  - Round-robin pointer `last` (1 bit).
- can_accept = ~full | (rsp_valid[owner] & rsp_ready[owner]). This lets the register drain and refill in the same cycle.
- Grant (combinational):
  - Only one valid: that requester.
  - Both valid: requester != last.
  - None valid: no grant.
- req_ready[i] = grant==i & can_accept. req_ready never depends on rsp_ready of a non-owner.
- ALU drive:
  - With a grant, alu_ctl/alu_a/alu_b = granted requester's fields, even when can_accept=0, so the ALU output is stable.
  - With no grant, drive alu_ctl=IDLE_CTL, alu_a=0, alu_b=0.
- Accept (req_valid[g] & req_ready[g] at a rising edge):
  - rsp_data<=alu_res, rsp_zero<=alu_zero, owner<=g, full<=1, last<=g.
  - busy_cnt increments and saturates at 16'hFFFF.
- Latency: 1 cycle. An operation accepted at edge N has rsp_valid[g]=1 after edge N.
- Throughput: 1 op/cycle while the owner holds rsp_ready=1.
- Drain: rsp_valid[owner] & rsp_ready[owner] with no new accept → full<=0.
- rsp_valid/rsp_data/rsp_zero:
  - Stable while the owner has rsp_ready=0 (backpressure).
  - rsp_ready on the non-owner bit is ignored.
- Requester obligation: once req_valid[i] is raised, hold req_valid[i] and the operation fields stable until req_ready[i] is seen. The arbiter does not check this.
- Zero is captured raw, including for non-compare ops. Requesters interpret rsp_zero only for SUB/SLT/SLTU/branch-compare codes.
- Simultaneous drain and accept by the other requester: allowed. Owner switches and the new data replaces the old in the same edge.
- Reset mid-operation: an in-flight response is discarded. No response is replayed after rst deasserts.

Test Plan:
- Single op: req_valid=01, ctl=ADD, a=5, b=7, rsp_ready=11 → req_ready=01 in cycle 0; next cycle rsp_valid=01, rsp_data=12, busy_cnt=1.
- Tie: req_valid=11, req0 SUB 9-9, req1 OR 0xF0|0x0F, rsp_ready=11 held.
  - Cycle 0: grant 0; then rsp_data=0, rsp_zero=1, rsp_valid=01.
  - Cycle 1: grant 1; then rsp_data=0xFF, rsp_valid=10.
- Backpressure: accept req0 ADD 1+1, rsp_ready=00 for 3 cycles while req1 is valid → req_ready=00, rsp_valid=01, rsp_data=2 stable. Raise rsp_ready[0] → req1 accepted that same cycle, rsp_valid=10 next.
- Fairness: both requesters continuously valid for 8 cycles with rsp_ready=11 → grants alternate 0,1,0,1…, busy_cnt=8.
- Idle drive: req_valid=00 → alu_ctl=IDLE_CTL, alu_a=0, alu_b=0, req_ready=00.
- Async reset while rsp_valid=10 → all outputs clear immediately without a clock edge. After release, tie with req_valid=11 grants requester 0.
